// File: rtl/sq_ctrl_pkg.sv
// Shared constants and types for the store-queue sequencing controller.
package sq_ctrl_pkg;

  localparam int unsigned SQ_SIZE = 8;
  localparam int unsigned PTR_W   = $clog2(SQ_SIZE);

  typedef logic [PTR_W:0] count_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } drain_state_e;

endpackage

// File: rtl/sq_ctrl_if.sv
// D-cache store request port: controller is master, cache is slave.
interface sq_ctrl_if #(
  parameter int unsigned PTR_W = sq_ctrl_pkg::PTR_W
);

  logic             mem_req_valid;
  logic [PTR_W-1:0] mem_req_idx;
  logic             mem_req_ready;

  modport master (
    output mem_req_valid,
    output mem_req_idx,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_idx,
    output mem_req_ready
  );

endinterface

// File: rtl/sq_ctrl_onehot.sv
// Range mask with wrap: sets len consecutive bits starting at ptr.
// len=1 yields a one-hot, len=0 yields zero.
module sq_ptr_onehot #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned PTR_W = $clog2(SIZE)
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [PTR_W:0]   len,
  output logic [SIZE-1:0]  mask
);

  logic [PTR_W-1:0] off;

  // Each bit is set when its distance from ptr (mod SIZE) is below len.
  always_comb begin
    mask = '0;
    off  = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      off     = PTR_W'(i) - ptr;
      mask[i] = ({1'b0, off} < len);
    end
  end

endmodule

// File: rtl/sq_ctrl.sv
// Store-queue sequencing controller: allocation, commit tracking, drain
// to the D-cache one store at a time, and clear pulses on drain/flush.
module sq_ctrl
  import sq_ctrl_pkg::*;
#(
  parameter int unsigned SQ_SIZE = sq_ctrl_pkg::SQ_SIZE,
  parameter int unsigned PTR_W   = $clog2(SQ_SIZE)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               disp_st_valid1,
  input  logic               disp_st_valid2,
  output logic [SQ_SIZE-1:0] sq_alloc1_onehot,
  output logic [SQ_SIZE-1:0] sq_alloc2_onehot,
  output logic               sq_stall,
  input  logic [1:0]         rob_st_commit_cnt,
  input  logic [SQ_SIZE-1:0] entry_ready,
  output logic [SQ_SIZE-1:0] sq_entry_clear,
  sq_ctrl_if.master          mem,
  input  logic               flush,
  output logic [PTR_W-1:0]   sq_head,
  output logic [PTR_W-1:0]   sq_tail,
  output logic [PTR_W:0]     sq_count
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  ptr_t head_q, commit_q, tail_q, idx_q;
  cnt_t count_q, ncommitted_q;
  drain_state_e state_q, state_n;

  logic accept, n1, n2, drain;
  cnt_t alloc_c, commit_c, drain_c, flush_len;
  ptr_t alloc_p, commit_p, slot2_ptr;
  logic [SQ_SIZE-1:0] drain_mask, flush_mask;

  assign sq_stall  = (count_q > cnt_t'(SQ_SIZE - 2));
  assign accept    = !sq_stall && !flush && !reset;
  assign n1        = disp_st_valid1 && accept;
  assign n2        = disp_st_valid2 && accept;
  assign alloc_c   = cnt_t'(n1) + cnt_t'(n2);
  assign alloc_p   = ptr_t'(n1) + ptr_t'(n2);
  assign commit_c  = cnt_t'(rob_st_commit_cnt);
  assign commit_p  = ptr_t'(rob_st_commit_cnt);
  assign drain_c   = cnt_t'(drain);
  assign slot2_ptr = tail_q + ptr_t'(n1);
  // Uncommitted entries left after this cycle's commit are the ones discarded.
  assign flush_len = (flush && !reset) ? (count_q - ncommitted_q - commit_c) : '0;

  sq_ptr_onehot #(.SIZE(SQ_SIZE), .PTR_W(PTR_W)) u_alloc1 (
    .ptr  (tail_q),
    .len  (cnt_t'(n1)),
    .mask (sq_alloc1_onehot)
  );

  sq_ptr_onehot #(.SIZE(SQ_SIZE), .PTR_W(PTR_W)) u_alloc2 (
    .ptr  (slot2_ptr),
    .len  (cnt_t'(n2)),
    .mask (sq_alloc2_onehot)
  );

  sq_ptr_onehot #(.SIZE(SQ_SIZE), .PTR_W(PTR_W)) u_drain (
    .ptr  (head_q),
    .len  (cnt_t'(drain && !reset)),
    .mask (drain_mask)
  );

  sq_ptr_onehot #(.SIZE(SQ_SIZE), .PTR_W(PTR_W)) u_flush (
    .ptr  (commit_q + commit_p),
    .len  (flush_len),
    .mask (flush_mask)
  );

  // Drained head is always committed, flushed range never is: masks are disjoint.
  assign sq_entry_clear = drain_mask | flush_mask;

  assign sq_head  = head_q;
  assign sq_tail  = tail_q;
  assign sq_count = count_q;

  // Queue pointers and occupancy counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q       <= '0;
      commit_q     <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ncommitted_q <= '0;
    end else begin
      head_q       <= head_q + ptr_t'(drain);
      commit_q     <= commit_q + commit_p;
      ncommitted_q <= ncommitted_q + commit_c - drain_c;
      if (flush) begin
        tail_q  <= commit_q + commit_p;
        count_q <= ncommitted_q + commit_c - drain_c;
      end else begin
        tail_q  <= tail_q + alloc_p;
        count_q <= count_q + alloc_c - drain_c;
      end
    end
  end

  // Drain FSM state register; request index captured on entry to ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == IDLE && state_n == ISSUE) idx_q <= head_q;
    end
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (ncommitted_q != '0 && entry_ready[head_q]) state_n = ISSUE;
      ISSUE:   if (mem.mem_req_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Drain FSM outputs.
  always_comb begin
    mem.mem_req_valid = (state_q == ISSUE);
    mem.mem_req_idx   = idx_q;
    drain             = (state_q == ISSUE) && mem.mem_req_ready;
  end

endmodule

// File: tb/tb_sq_ctrl.sv
module tb_sq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       disp_st_valid1, disp_st_valid2;
  logic [7:0] sq_alloc1_onehot, sq_alloc2_onehot;
  logic       sq_stall;
  logic [1:0] rob_st_commit_cnt;
  logic [7:0] entry_ready;
  logic [7:0] sq_entry_clear;
  logic       flush;
  logic [2:0] sq_head, sq_tail;
  logic [3:0] sq_count;

  int n_tests = 0;
  int n_fail  = 0;

  sq_ctrl_if #(.PTR_W(3)) mem_bus ();

  sq_ctrl #(.SQ_SIZE(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .disp_st_valid1    (disp_st_valid1),
    .disp_st_valid2    (disp_st_valid2),
    .sq_alloc1_onehot  (sq_alloc1_onehot),
    .sq_alloc2_onehot  (sq_alloc2_onehot),
    .sq_stall          (sq_stall),
    .rob_st_commit_cnt (rob_st_commit_cnt),
    .entry_ready       (entry_ready),
    .sq_entry_clear    (sq_entry_clear),
    .mem               (mem_bus),
    .flush             (flush),
    .sq_head           (sq_head),
    .sq_tail           (sq_tail),
    .sq_count          (sq_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset) begin
      assert ({2'b00, rob_st_commit_cnt} <= sq_count)
        else $error("commit count exceeds occupied entries");
    end
  end

  typedef struct {
    logic       v1;
    logic       v2;
    logic [7:0] a1;
    logic [7:0] a2;
    logic       stall;
    logic [2:0] tail;
    logic [3:0] count;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 3'd2, 4'd2};
    vecs[1] = '{1'b1, 1'b1, 8'h04, 8'h08, 1'b0, 3'd4, 4'd4};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 3'd5, 4'd5};
    vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 3'd6, 4'd6};
    vecs[4] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 3'd7, 4'd7};
    vecs[5] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 3'd7, 4'd7};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd7, 4'd7};

    reset = 1'b1;
    disp_st_valid1 = 1'b0;
    disp_st_valid2 = 1'b0;
    rob_st_commit_cnt = 2'd0;
    entry_ready = 8'h00;
    flush = 1'b0;
    mem_bus.mem_req_ready = 1'b0;
    tick();
    tick();
    check("rst_count", sq_count, 0);
    check("rst_head", sq_head, 0);
    check("rst_tail", sq_tail, 0);
    check("rst_stall", sq_stall, 0);
    check("rst_valid", mem_bus.mem_req_valid, 0);
    check("rst_idx", mem_bus.mem_req_idx, 0);
    check("rst_clear", sq_entry_clear, 0);
    reset = 1'b0;

    // Fill sequence from the table.
    for (int i = 0; i < 7; i++) begin
      disp_st_valid1 = vecs[i].v1;
      disp_st_valid2 = vecs[i].v2;
      @(negedge clock);
      check($sformatf("vec%0d_alloc1", i), sq_alloc1_onehot, vecs[i].a1);
      check($sformatf("vec%0d_alloc2", i), sq_alloc2_onehot, vecs[i].a2);
      check($sformatf("vec%0d_stall", i), sq_stall, vecs[i].stall);
      tick();
      check($sformatf("vec%0d_tail", i), sq_tail, vecs[i].tail);
      check($sformatf("vec%0d_count", i), sq_count, vecs[i].count);
    end
    disp_st_valid1 = 1'b0;
    disp_st_valid2 = 1'b0;

    // Commit one, head ready, cache backpressure for 3 cycles.
    rob_st_commit_cnt = 2'd1;
    entry_ready = 8'h01;
    tick();
    rob_st_commit_cnt = 2'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("hold%0d_valid", i), mem_bus.mem_req_valid, 1);
      check($sformatf("hold%0d_idx", i), mem_bus.mem_req_idx, 0);
      check($sformatf("hold%0d_clear", i), sq_entry_clear, 0);
      tick();
    end
    mem_bus.mem_req_ready = 1'b1;
    @(negedge clock);
    check("hs_clear", sq_entry_clear, 8'h01);
    tick();
    mem_bus.mem_req_ready = 1'b0;
    check("hs_head", sq_head, 1);
    check("hs_count", sq_count, 6);
    check("hs_valid", mem_bus.mem_req_valid, 0);

    // Commit the rest and drain everything so head/tail sit at 7.
    entry_ready = 8'hFF;
    mem_bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rob_st_commit_cnt = 2'd2;
      tick();
    end
    rob_st_commit_cnt = 2'd0;
    begin
      int guard;
      guard = 0;
      while (sq_count != 0 && guard < 60) begin
        tick();
        guard++;
      end
      check("drain_timeout", (guard < 60), 1);
    end
    mem_bus.mem_req_ready = 1'b0;
    entry_ready = 8'h00;
    check("empty_head", sq_head, 7);
    check("empty_tail", sq_tail, 7);

    // Wrap allocation from tail 7.
    disp_st_valid1 = 1'b1;
    disp_st_valid2 = 1'b1;
    @(negedge clock);
    check("wrap_alloc1", sq_alloc1_onehot, 8'h80);
    check("wrap_alloc2", sq_alloc2_onehot, 8'h01);
    check("wrap_stall", sq_stall, 0);
    tick();
    check("wrap_tail", sq_tail, 1);
    check("wrap_count", sq_count, 2);
    disp_st_valid1 = 1'b0;
    disp_st_valid2 = 1'b0;

    // Flush with a concurrent commit.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    disp_st_valid1 = 1'b1;
    disp_st_valid2 = 1'b1;
    tick();
    tick();
    disp_st_valid1 = 1'b0;
    disp_st_valid2 = 1'b0;
    rob_st_commit_cnt = 2'd2;
    tick();
    disp_st_valid1 = 1'b1;
    disp_st_valid2 = 1'b1;
    rob_st_commit_cnt = 2'd1;
    flush = 1'b1;
    @(negedge clock);
    check("flush_clear", sq_entry_clear, 8'h08);
    check("flush_alloc1", sq_alloc1_onehot, 8'h00);
    check("flush_alloc2", sq_alloc2_onehot, 8'h00);
    tick();
    flush = 1'b0;
    rob_st_commit_cnt = 2'd0;
    disp_st_valid1 = 1'b0;
    disp_st_valid2 = 1'b0;
    check("flush_tail", sq_tail, 3);
    check("flush_count", sq_count, 3);
    check("flush_head", sq_head, 0);

    // Reset in the middle of an ISSUE.
    entry_ready = 8'h01;
    begin
      int guard;
      guard = 0;
      while (mem_bus.mem_req_valid !== 1'b1 && guard < 10) begin
        tick();
        guard++;
      end
      check("issue_timeout", (guard < 10), 1);
    end
    reset = 1'b1;
    @(negedge clock);
    check("rstiss_clear", sq_entry_clear, 0);
    tick();
    check("rstiss_valid", mem_bus.mem_req_valid, 0);
    check("rstiss_count", sq_count, 0);
    check("rstiss_tail", sq_tail, 0);
    reset = 1'b0;
    entry_ready = 8'h00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
